xgxssynth_lane_sync: RTL and testbench

XGXSSYNTH_LANE_SYNC -- requirements
Module: xgxssynth_lane_sync

---
 rtl/xgxssynth_lane_sync_if.sv | 24 ++
 rtl/xgxssynth_lane_sync.sv | 114 +++++++++++
 tb/tb_xgxssynth_lane_sync.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/xgxssynth_lane_sync_if.sv
// Lane synchronisation bus: decoder-side inputs and sync-state outputs of one XGXS lane.
// master = upstream PCS/decoder side, slave = the lane sync block.
interface xgxssynth_lane_sync_if;
  logic       signal_detect;
  logic       cg_valid;
  logic [9:0] code_group;
  logic       code_bad;
  logic       sync_status;
  logic       enable_cgalign;
  logic [2:0] lane_state;
  logic       sync_acq;
  logic       sync_lost;
  logic [7:0] bad_cnt;

  modport master (
    output signal_detect, cg_valid, code_group, code_bad,
    input  sync_status, enable_cgalign, lane_state, sync_acq, sync_lost, bad_cnt
  );

  modport slave (
    input  signal_detect, cg_valid, code_group, code_bad,
    output sync_status, enable_cgalign, lane_state, sync_acq, sync_lost, bad_cnt
  );
endinterface

// File: rtl/xgxssynth_lane_sync.sv
// XGXS lane synchronisation state machine: comma acquisition, hysteretic SA1..SA4 tracking
// and a saturating bad code-group counter. No valid/ready handshake: cg_valid is a plain qualifier.
module xgxssynth_lane_sync #(
  parameter int GOOD_CGS_LIMIT = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  xgxssynth_lane_sync_if.slave lane
);

  typedef enum logic [2:0] {
    LOSS_OF_SYNC = 3'd0,
    CD1          = 3'd1,
    CD2          = 3'd2,
    CD3          = 3'd3,
    SA1          = 3'd4,
    SA2          = 3'd5,
    SA3          = 3'd6,
    SA4          = 3'd7
  } state_e;

  localparam logic [2:0] GOOD_LAST = 3'(GOOD_CGS_LIMIT - 1);

  state_e     state_q, state_d;
  logic [2:0] good_cgs_q, good_cgs_d;
  logic [7:0] bad_cnt_q, bad_cnt_d;
  logic       sync_status_q, sync_status_d;
  logic       enable_cgalign_q, enable_cgalign_d;
  logic       sync_acq_q, sync_acq_d;
  logic       sync_lost_q, sync_lost_d;

  logic comma, cgbad, cggood;

  assign comma  = (lane.code_group[9:3] == 7'b0011111) || (lane.code_group[9:3] == 7'b1100000);
  assign cgbad  = lane.cg_valid & lane.code_bad;
  assign cggood = lane.cg_valid & ~lane.code_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= LOSS_OF_SYNC;
      good_cgs_q       <= 3'd0;
      bad_cnt_q        <= 8'd0;
      sync_status_q    <= 1'b0;
      enable_cgalign_q <= 1'b1;
      sync_acq_q       <= 1'b0;
      sync_lost_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      good_cgs_q       <= good_cgs_d;
      bad_cnt_q        <= bad_cnt_d;
      sync_status_q    <= sync_status_d;
      enable_cgalign_q <= enable_cgalign_d;
      sync_acq_q       <= sync_acq_d;
      sync_lost_q      <= sync_lost_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    good_cgs_d = good_cgs_q;

    if (!lane.signal_detect) begin
      state_d    = LOSS_OF_SYNC;
      good_cgs_d = 3'd0;
    end else if (lane.cg_valid) begin
      case (state_q)
        LOSS_OF_SYNC: begin
          if (cggood && comma) state_d = CD1;
        end
        CD1, CD2, CD3: begin
          // CD3 + 1 encodes SA1, so the comma step covers acquisition too
          if (cgbad)       state_d = LOSS_OF_SYNC;
          else if (comma)  state_d = state_e'(state_q + 3'd1);
        end
        SA1: begin
          if (cgbad) state_d = SA2;
        end
        SA2, SA3, SA4: begin
          if (cgbad) begin
            state_d = (state_q == SA4) ? LOSS_OF_SYNC : state_e'(state_q + 3'd1);
          end else if (good_cgs_q == GOOD_LAST) begin
            state_d = state_e'(state_q - 3'd1);
          end else begin
            good_cgs_d = good_cgs_q + 3'd1;
          end
        end
        default: state_d = LOSS_OF_SYNC;
      endcase
    end

    // The good-run counter only ever measures time spent in the current state
    if (state_d != state_q) good_cgs_d = 3'd0;
  end

  always_comb begin
    sync_status_d    = state_d[2];
    enable_cgalign_d = ~state_d[2];
    sync_acq_d       = (state_q == CD3) && (state_d == SA1);
    sync_lost_d      = state_q[2] && (state_d == LOSS_OF_SYNC);

    bad_cnt_d = bad_cnt_q;
    if (cgbad && sync_status_q && (bad_cnt_q != 8'hFF)) bad_cnt_d = bad_cnt_q + 8'd1;
  end

  assign lane.lane_state     = state_q;
  assign lane.sync_status    = sync_status_q;
  assign lane.enable_cgalign = enable_cgalign_q;
  assign lane.sync_acq       = sync_acq_q;
  assign lane.sync_lost      = sync_lost_q;
  assign lane.bad_cnt        = bad_cnt_q;

  a_pulse_excl: assert property (@(posedge clk) disable iff (!rst_n) !(sync_acq_q && sync_lost_q));

endmodule

// File: tb/tb_xgxssynth_lane_sync.sv
// Directed bench for xgxssynth_lane_sync: a vector table for the main walk through every state,
// then hand sequences for gating, signal loss, comma abort, counter saturation and async reset.
module tb_xgxssynth_lane_sync;

  localparam logic [9:0] CM = 10'b0011111010;
  localparam logic [9:0] DT = 10'b0101010101;

  typedef struct {
    logic       sd;
    logic       v;
    logic [9:0] cg;
    logic       bad;
    logic [2:0] st;
    logic       status;
    logic       align;
    logic       acq;
    logic       lost;
    logic [7:0] cnt;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  vec_t vecs[$];

  xgxssynth_lane_sync_if lif ();

  xgxssynth_lane_sync #(.GOOD_CGS_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .lane  (lif.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic sd, input logic v, input logic [9:0] cg, input logic bad);
    lif.signal_detect = sd;
    lif.cg_valid      = v;
    lif.code_group    = cg;
    lif.code_bad      = bad;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [2:0] st, input logic status,
                           input logic align, input logic acq, input logic lost,
                           input logic [7:0] cnt);
    check({tag, " lane_state"}, 32'(lif.lane_state), 32'(st));
    check({tag, " sync_status"}, 32'(lif.sync_status), 32'(status));
    check({tag, " enable_cgalign"}, 32'(lif.enable_cgalign), 32'(align));
    check({tag, " sync_acq"}, 32'(lif.sync_acq), 32'(acq));
    check({tag, " sync_lost"}, 32'(lif.sync_lost), 32'(lost));
    check({tag, " bad_cnt"}, 32'(lif.bad_cnt), 32'(cnt));
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, DT, 1'b0);
    rst_n = 1'b0;
    repeat (3) step();
    check_all("reset", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, DT, 1'b0);
    step();
  endtask

  task automatic acquire(input string tag);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, CM, 1'b0);
      step();
      check({tag, " acq lane_state"}, 32'(lif.lane_state), i + 1);
      check({tag, " acq sync_acq"}, 32'(lif.sync_acq), (i == 3) ? 1 : 0);
    end
    check({tag, " acq sync_status"}, 32'(lif.sync_status), 1);
    check({tag, " acq enable_cgalign"}, 32'(lif.enable_cgalign), 0);
  endtask

  task automatic add(input logic sd, input logic v, input logic [9:0] cg, input logic bad,
                     input logic [2:0] st, input logic status, input logic align,
                     input logic acq, input logic lost, input logic [7:0] cnt);
    vec_t e;
    e.sd = sd; e.v = v; e.cg = cg; e.bad = bad;
    e.st = st; e.status = status; e.align = align; e.acq = acq; e.lost = lost; e.cnt = cnt;
    vecs.push_back(e);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(1'b0, 1'b0, DT, 1'b0);

    //   sd    v     cg  bad    st    stat  algn  acq   lost  cnt
    add(1'b1, 1'b1, CM, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    add(1'b1, 1'b1, CM, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    add(1'b1, 1'b1, DT, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    add(1'b1, 1'b0, CM, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    add(1'b1, 1'b1, CM, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    add(1'b1, 1'b1, CM, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    add(1'b1, 1'b1, DT, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b1, 1'b1, DT, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    add(1'b1, 1'b1, DT, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    add(1'b1, 1'b1, DT, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    add(1'b1, 1'b1, DT, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    add(1'b1, 1'b1, DT, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    add(1'b1, 1'b1, DT, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
    add(1'b1, 1'b1, DT, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
    add(1'b1, 1'b1, DT, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4);
    add(1'b1, 1'b1, DT, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4);
    add(1'b1, 1'b1, DT, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4);
    add(1'b1, 1'b1, DT, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4);
    add(1'b1, 1'b1, DT, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4);
    add(1'b1, 1'b1, DT, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
    add(1'b1, 1'b1, DT, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd6);
    add(1'b1, 1'b1, DT, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd6);
    add(1'b1, 1'b1, CM, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd6);
    add(1'b1, 1'b1, CM, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd6);
    add(1'b1, 1'b1, CM, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd6);

    do_reset();
    foreach (vecs[i]) begin
      drive(vecs[i].sd, vecs[i].v, vecs[i].cg, vecs[i].bad);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].status, vecs[i].align,
                vecs[i].acq, vecs[i].lost, vecs[i].cnt);
    end

    // Gating in SA3, then signal loss from SA1
    do_reset();
    acquire("gate");
    drive(1'b1, 1'b1, DT, 1'b1); step();
    drive(1'b1, 1'b1, DT, 1'b1); step();
    check("gate enter SA3", 32'(lif.lane_state), 6);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, DT, 1'b1);
      step();
      check($sformatf("gate hold%0d lane_state", i), 32'(lif.lane_state), 6);
      check($sformatf("gate hold%0d bad_cnt", i), 32'(lif.bad_cnt), 2);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, DT, 1'b0);
      step();
      check($sformatf("gate climb%0d lane_state", i), 32'(lif.lane_state),
            (i < 3) ? 6 : (i < 7) ? 5 : 4);
    end
    drive(1'b0, 1'b0, DT, 1'b0);
    step();
    check_all("sd_drop", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2);
    step();
    check_all("sd_drop+1", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2);

    // Comma abort from CD2
    do_reset();
    drive(1'b1, 1'b1, CM, 1'b0); step();
    drive(1'b1, 1'b1, CM, 1'b0); step();
    check("cd2 reached", 32'(lif.lane_state), 2);
    drive(1'b1, 1'b1, CM, 1'b1); step();
    check_all("cd2 abort", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);

    // bad_cnt saturation over 300 bad/recover cycles
    do_reset();
    acquire("sat");
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b1, DT, 1'b1);
      step();
      check($sformatf("sat%0d bad_cnt", i), 32'(lif.bad_cnt), (i + 1 > 255) ? 255 : i + 1);
      repeat (4) begin
        drive(1'b1, 1'b1, DT, 1'b0);
        step();
      end
    end
    check_all("sat end", 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'd255);

    // Asynchronous reset between edges while in SA2
    do_reset();
    acquire("arst");
    drive(1'b1, 1'b1, DT, 1'b1);
    step();
    check("arst in SA2", 32'(lif.lane_state), 5);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("arst async", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    step();
    check_all("arst held", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, CM, 1'b0);
    step();
    check_all("arst resume", 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
